// File: rtl/ysyx_040750_data_st_if.sv
`timescale 1ns/1ps
`default_nettype none
// ysyx_040750_data_st_if: store request channel plus data-memory write channel (AW/W/B).
// Rev 1.0
interface ysyx_040750_data_st_if;
  logic        I_st_valid;
  logic        O_st_ready;
  logic [63:0] I_st_addr;
  logic [63:0] I_st_data;
  logic [1:0]  I_st_size;
  logic        O_st_done;
  logic        O_st_err;
  logic        O_mem_awvalid;
  logic        I_mem_awready;
  logic [63:0] O_mem_awaddr;
  logic        O_mem_wvalid;
  logic        I_mem_wready;
  logic [63:0] O_mem_wdata;
  logic [7:0]  O_mem_wstrb;
  logic        I_mem_bvalid;
  logic        O_mem_bready;
  logic [1:0]  I_mem_bresp;

  modport slave (
    input  I_st_valid, I_st_addr, I_st_data, I_st_size,
    input  I_mem_awready, I_mem_wready, I_mem_bvalid, I_mem_bresp,
    output O_st_ready, O_st_done, O_st_err,
    output O_mem_awvalid, O_mem_awaddr, O_mem_wvalid, O_mem_wdata, O_mem_wstrb, O_mem_bready
  );

  modport master (
    output I_st_valid, I_st_addr, I_st_data, I_st_size,
    output I_mem_awready, I_mem_wready, I_mem_bvalid, I_mem_bresp,
    input  O_st_ready, O_st_done, O_st_err,
    input  O_mem_awvalid, O_mem_awaddr, O_mem_wvalid, O_mem_wdata, O_mem_wstrb, O_mem_bready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_040750_data_st.sv
`timescale 1ns/1ps
`default_nettype none
// ysyx_040750_data_st: aligns a store into byte lanes and issues one or two AW/W/B bus writes.
// Rev 1.0
module ysyx_040750_data_st #(
  parameter bit P_ALLOW_SPLIT = 1'b1
) (
  input  wire logic              I_sys_clk,
  input  wire logic              I_rst,
  ysyx_040750_data_st_if.slave   io_st
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic          r_awvalid, r_wvalid, r_err, r_beat1;
  logic [63:0]   r_awaddr, r_wdata, r_b1_data;
  logic [7:0]    r_wstrb, r_b1_strb;

  logic [7:0]    w_mask;
  logic [15:0]   w_strb16;
  logic [127:0]  w_data128;
  logic          w_split, w_reject, w_accept, w_xfer_end, w_b_fire, w_b_err;

  // Lane placement across a 16-byte window; the upper half is the second beat.
  always_comb begin
    case (io_st.I_st_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
    w_strb16  = {8'h00, w_mask} << io_st.I_st_addr[2:0];
    w_data128 = {64'h0, io_st.I_st_data} << {io_st.I_st_addr[2:0], 3'b000};
  end

  assign w_split    = |w_strb16[15:8];
  assign w_reject   = w_split && !P_ALLOW_SPLIT;
  assign w_accept   = (r_state == S_IDLE) && io_st.I_st_valid;
  assign w_xfer_end = (r_state == S_XFER) && (!r_awvalid || io_st.I_mem_awready)
                                          && (!r_wvalid  || io_st.I_mem_wready);
  assign w_b_fire   = (r_state == S_RESP) && io_st.I_mem_bvalid;
  assign w_b_err    = |io_st.I_mem_bresp;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_st.I_st_valid) w_next = w_reject ? S_DONE : S_XFER;
      S_XFER:  if (w_xfer_end) w_next = S_RESP;
      S_RESP:  if (w_b_fire) w_next = (w_b_err || !r_beat1) ? S_DONE : S_XFER;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_st.O_st_ready    = (r_state == S_IDLE);
    io_st.O_st_done     = (r_state == S_DONE);
    io_st.O_st_err      = (r_state == S_DONE) && r_err;
    io_st.O_mem_bready  = (r_state == S_RESP);
    io_st.O_mem_awvalid = r_awvalid;
    io_st.O_mem_wvalid  = r_wvalid;
    io_st.O_mem_awaddr  = r_awaddr;
    io_st.O_mem_wdata   = r_wdata;
    io_st.O_mem_wstrb   = r_wstrb;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_beat1   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_b1_data <= '0;
      r_b1_strb <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_err     <= w_reject;
          r_beat1   <= w_split;
          r_b1_data <= w_data128[127:64];
          r_b1_strb <= w_strb16[15:8];
          if (!w_reject) begin
            r_awaddr  <= {io_st.I_st_addr[63:3], 3'b000};
            r_wdata   <= w_data128[63:0];
            r_wstrb   <= w_strb16[7:0];
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_XFER: begin
          if (io_st.I_mem_awready) r_awvalid <= 1'b0;
          if (io_st.I_mem_wready)  r_wvalid  <= 1'b0;
        end
        S_RESP: if (w_b_fire) begin
          r_err <= w_b_err;
          // An errored first beat leaves r_beat1 set but unused; DONE follows.
          if (!w_b_err && r_beat1) begin
            r_beat1   <= 1'b0;
            r_awaddr  <= r_awaddr + 64'd8;
            r_wdata   <= r_b1_data;
            r_wstrb   <= r_b1_strb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040750_data_st.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ysyx_040750_data_st: directed stores with a scoreboard checking AW/W beats and completions.
// Rev 1.0
module tb_ysyx_040750_data_st;

  typedef struct {
    logic [7:0]  strb;
    logic [63:0] data;
  } w_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_040750_data_st_if u_if ();
  ysyx_040750_data_st_if u_if_ns ();

  ysyx_040750_data_st #(.P_ALLOW_SPLIT(1'b1)) dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .io_st     (u_if)
  );

  ysyx_040750_data_st #(.P_ALLOW_SPLIT(1'b0)) dut_ns (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .io_st     (u_if_ns)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int aw_fire_cnt = 0;
  int ns_done_cnt = 0;
  int ns_last_done_cyc = 0;
  logic ns_last_err = 1'b0;
  int ns_bus_seen = 0;
  int aw_stall = 0;
  int aw_wait = 0;
  bit b_block = 1'b0;

  logic [63:0] exp_aw_q[$];
  w_exp_t      exp_w_q[$];
  logic        exp_done_q[$];
  logic [1:0]  bresp_q[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] mask64(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder for the split-capable instance
  initial begin
    u_if.I_mem_awready = 1'b0;
    u_if.I_mem_wready  = 1'b0;
    u_if.I_mem_bvalid  = 1'b0;
    u_if.I_mem_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (u_if.O_mem_awvalid && aw_wait < aw_stall) begin
        u_if.I_mem_awready = 1'b0;
        aw_wait++;
      end else begin
        u_if.I_mem_awready = 1'b1;
        aw_wait = 0;
      end
      u_if.I_mem_wready = 1'b1;
      if (u_if.O_mem_bready && !b_block) begin
        u_if.I_mem_bvalid = 1'b1;
        u_if.I_mem_bresp  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
      end else begin
        u_if.I_mem_bvalid = 1'b0;
        u_if.I_mem_bresp  = 2'b00;
      end
    end
  end

  initial begin
    u_if_ns.I_mem_awready = 1'b1;
    u_if_ns.I_mem_wready  = 1'b1;
    u_if_ns.I_mem_bvalid  = 1'b0;
    u_if_ns.I_mem_bresp   = 2'b00;
  end

  // Monitor: samples just before the rising edge, after the responder has settled
  initial forever begin
    @(negedge clk);
    #2;
    if (u_if.O_mem_awvalid && u_if.I_mem_awready) begin
      aw_fire_cnt++;
      if (exp_aw_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL aw_unexpected actual=0x%0h required=none", u_if.O_mem_awaddr);
      end else chk("awaddr", u_if.O_mem_awaddr, exp_aw_q.pop_front());
    end
    if (u_if.O_mem_wvalid && u_if.I_mem_wready) begin
      if (exp_w_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL w_unexpected actual=0x%0h required=none", u_if.O_mem_wstrb);
      end else begin
        w_exp_t e;
        e = exp_w_q.pop_front();
        chk("wstrb", {56'h0, u_if.O_mem_wstrb}, {56'h0, e.strb});
        chk("wdata", u_if.O_mem_wdata & mask64(e.strb), e.data & mask64(e.strb));
      end
    end
    if (u_if.O_st_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_done_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else chk("st_err", {63'h0, u_if.O_st_err}, {63'h0, exp_done_q.pop_front()});
    end
    if (u_if_ns.O_mem_awvalid || u_if_ns.O_mem_wvalid) ns_bus_seen++;
    if (u_if_ns.O_st_done) begin
      ns_done_cnt++;
      ns_last_done_cyc = cyc;
      ns_last_err = u_if_ns.O_st_err;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                       output int acc);
    int n;
    @(negedge clk);
    u_if.I_st_valid = 1'b1;
    u_if.I_st_addr  = a;
    u_if.I_st_data  = d;
    u_if.I_st_size  = s;
    n = 0;
    while (!u_if.O_st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
    acc = cyc;
    @(negedge clk);
    u_if.I_st_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, target);
    end
  endtask

  initial begin
    int acc, acc2, prev, prev_aw, n;
    u_if.I_st_valid = 1'b0;
    u_if.I_st_addr  = '0;
    u_if.I_st_data  = '0;
    u_if.I_st_size  = '0;
    u_if_ns.I_st_valid = 1'b0;
    u_if_ns.I_st_addr  = '0;
    u_if_ns.I_st_data  = '0;
    u_if_ns.I_st_size  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready",   {63'h0, u_if.O_st_ready}, 64'd1);
    chk("rst_done",    {63'h0, u_if.O_st_done}, 64'd0);
    chk("rst_awvalid", {63'h0, u_if.O_mem_awvalid}, 64'd0);
    chk("rst_wvalid",  {63'h0, u_if.O_mem_wvalid}, 64'd0);
    chk("rst_bready",  {63'h0, u_if.O_mem_bready}, 64'd0);
    chk("rst_awaddr",  u_if.O_mem_awaddr, 64'd0);
    chk("rst_wstrb",   {56'h0, u_if.O_mem_wstrb}, 64'd0);
    chk("rst_wdata",   u_if.O_mem_wdata, 64'd0);
    rst = 1'b0;

    // sb at byte 5
    exp_aw_q.push_back(64'h8000_0000);
    exp_w_q.push_back('{strb: 8'h20, data: 64'h0000_AB00_0000_0000});
    exp_done_q.push_back(1'b0);
    prev = done_cnt;
    issue(64'h8000_0005, 64'hDEAD_BEEF_CAFE_12AB, 2'd0, acc);
    wait_done(prev + 1);
    chk("sb_latency", 64'(last_done_cyc - acc), 64'd3);

    // sd crossing a doubleword boundary
    exp_aw_q.push_back(64'h1000);
    exp_aw_q.push_back(64'h1008);
    exp_w_q.push_back('{strb: 8'hF8, data: 64'h4455_6677_8800_0000});
    exp_w_q.push_back('{strb: 8'h07, data: 64'h0000_0000_0011_2233});
    exp_done_q.push_back(1'b0);
    prev = done_cnt;
    issue(64'h1003, 64'h1122_3344_5566_7788, 2'd3, acc);
    wait_done(prev + 1);
    chk("sd_latency", 64'(last_done_cyc - acc), 64'd5);
    repeat (5) @(negedge clk);
    chk("sd_one_done", 64'(done_cnt), 64'(prev + 1));

    // AW backpressure for 3 cycles, W accepted at once
    aw_stall = 3;
    exp_aw_q.push_back(64'h10);
    exp_w_q.push_back('{strb: 8'h0F, data: 64'h1234_5678});
    exp_done_q.push_back(1'b0);
    prev = done_cnt;
    issue(64'h10, 64'h1234_5678, 2'd2, acc);
    chk("bp_wvalid_t1", {63'h0, u_if.O_mem_wvalid}, 64'd1);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk("bp_awvalid", {63'h0, u_if.O_mem_awvalid}, 64'd1);
      chk("bp_awaddr", u_if.O_mem_awaddr, 64'h10);
      chk("bp_bready_lo", {63'h0, u_if.O_mem_bready}, 64'd0);
      if (k > 1) chk("bp_wvalid_lo", {63'h0, u_if.O_mem_wvalid}, 64'd0);
    end
    @(negedge clk);
    chk("bp_awvalid_drop", {63'h0, u_if.O_mem_awvalid}, 64'd0);
    chk("bp_bready_hi", {63'h0, u_if.O_mem_bready}, 64'd1);
    wait_done(prev + 1);
    chk("bp_latency", 64'(last_done_cyc - acc), 64'd6);
    aw_stall = 0;

    // split sw with error on beat0 suppresses beat1
    bresp_q.push_back(2'b10);
    exp_aw_q.push_back(64'h1000);
    exp_w_q.push_back('{strb: 8'hC0, data: 64'hCCDD_0000_0000_0000});
    exp_done_q.push_back(1'b1);
    prev = done_cnt;
    prev_aw = aw_fire_cnt;
    issue(64'h1006, 64'hAABB_CCDD, 2'd2, acc);
    wait_done(prev + 1);
    chk("err_latency", 64'(last_done_cyc - acc), 64'd3);
    repeat (4) @(negedge clk);
    chk("err_no_beat1", 64'(aw_fire_cnt), 64'(prev_aw + 1));

    // same store rejected when splitting is disabled
    @(negedge clk);
    u_if_ns.I_st_valid = 1'b1;
    u_if_ns.I_st_addr  = 64'h1006;
    u_if_ns.I_st_data  = 64'hAABB_CCDD;
    u_if_ns.I_st_size  = 2'd2;
    chk("ns_ready", {63'h0, u_if_ns.O_st_ready}, 64'd1);
    acc = cyc;
    @(negedge clk);
    u_if_ns.I_st_valid = 1'b0;
    n = 0;
    while (ns_done_cnt == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ns_done_cnt", 64'(ns_done_cnt), 64'd1);
    chk("ns_latency", 64'(ns_last_done_cyc - acc), 64'd1);
    chk("ns_err", {63'h0, ns_last_err}, 64'd1);
    chk("ns_no_bus", 64'(ns_bus_seen), 64'd0);

    // reset while waiting for the write response
    b_block = 1'b1;
    exp_aw_q.push_back(64'h20);
    exp_w_q.push_back('{strb: 8'h0F, data: 64'h5566_7788});
    prev = done_cnt;
    issue(64'h20, 64'h5566_7788, 2'd2, acc);
    n = 0;
    while (!u_if.O_mem_bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rr_in_resp", {63'h0, u_if.O_mem_bready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_block = 1'b0;
    chk("rr_ready",   {63'h0, u_if.O_st_ready}, 64'd1);
    chk("rr_bready",  {63'h0, u_if.O_mem_bready}, 64'd0);
    chk("rr_awvalid", {63'h0, u_if.O_mem_awvalid}, 64'd0);
    chk("rr_wvalid",  {63'h0, u_if.O_mem_wvalid}, 64'd0);
    chk("rr_awaddr",  u_if.O_mem_awaddr, 64'd0);
    chk("rr_wstrb",   {56'h0, u_if.O_mem_wstrb}, 64'd0);
    repeat (3) @(negedge clk);
    chk("rr_no_done", 64'(done_cnt), 64'(prev));
    exp_aw_q.push_back(64'h0);
    exp_w_q.push_back('{strb: 8'h0C, data: 64'hBEEF_0000});
    exp_done_q.push_back(1'b0);
    issue(64'h2, 64'hBEEF, 2'd1, acc);
    wait_done(prev + 1);
    chk("sh_latency", 64'(last_done_cyc - acc), 64'd3);

    // back-to-back sw with valid held high
    exp_aw_q.push_back(64'h0);
    exp_aw_q.push_back(64'h0);
    exp_w_q.push_back('{strb: 8'h0F, data: 64'h1111_1111});
    exp_w_q.push_back('{strb: 8'hF0, data: 64'h2222_2222_0000_0000});
    exp_done_q.push_back(1'b0);
    exp_done_q.push_back(1'b0);
    prev = done_cnt;
    @(negedge clk);
    u_if.I_st_valid = 1'b1;
    u_if.I_st_addr  = 64'h0;
    u_if.I_st_data  = 64'h1111_1111;
    u_if.I_st_size  = 2'd2;
    chk("b2b_ready0", {63'h0, u_if.O_st_ready}, 64'd1);
    acc = cyc;
    @(negedge clk);
    u_if.I_st_addr = 64'h4;
    u_if.I_st_data = 64'h2222_2222;
    n = 0;
    while (!u_if.O_st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc2 = cyc;
    @(negedge clk);
    u_if.I_st_valid = 1'b0;
    chk("b2b_gap", 64'(acc2 - acc), 64'd4);
    wait_done(prev + 2);
    chk("b2b_latency", 64'(last_done_cyc - acc2), 64'd3);

    repeat (5) @(negedge clk);
    chk("left_aw", 64'(exp_aw_q.size()), 64'd0);
    chk("left_w", 64'(exp_w_q.size()), 64'd0);
    chk("left_done", 64'(exp_done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
